// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, flush/hold handling and a bubble counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        id_opcode,
    input  logic              id_alusrc,
    input  logic              id_memtoreg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic [1:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [2:0]        id_funct3,
    input  logic [6:0]        id_funct7,
    input  logic              flush,
    input  logic              hold,
    output logic              ex_alusrc,
    output logic              ex_memtoreg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic [1:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic [REG_W-1:0]  ex_rd,
    output logic [2:0]        ex_funct3,
    output logic [6:0]        ex_funct7,
    output logic              ex_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);
    localparam int BW = 18 + 4 * DATA_W + 3 * REG_W;

    logic [BW-1:0]    w_id_bundle;
    logic [BW-1:0]    r_bundle;
    logic             r_valid;
    logic [CNT_W-1:0] r_cnt;
    logic             w_uses_rs1;
    logic             w_uses_rs2;
    logic             w_haz;
    logic             w_bubble;

    assign w_id_bundle = {id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch,
                          id_aluop, id_pc, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
                          id_funct3, id_funct7};
    assign {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
            ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
            ex_funct3, ex_funct7} = r_bundle;
    assign ex_valid   = r_valid;
    assign bubble_cnt = r_cnt;

    // LUI and JAL ignore rs1; only R-type, stores and branches read rs2
    assign w_uses_rs1 = (id_opcode != 7'b0110111) && (id_opcode != 7'b1101111);
    assign w_uses_rs2 = (id_opcode == 7'b0110011) || (id_opcode == 7'b0100011) || (id_opcode == 7'b1100011);
    assign w_haz      = r_valid & ex_memread & (ex_rd != '0) &
                        ((w_uses_rs1 & (ex_rd == id_rs1)) | (w_uses_rs2 & (ex_rd == id_rs2)));
    assign stall      = w_haz & ~flush & ~hold;
    assign w_bubble   = flush | (w_haz & ~hold);

    // flush beats hold beats hazard; a bubble zeroes the whole slot and bumps the saturating counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bundle <= '0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_bubble) begin
            r_bundle <= '0;
            r_valid  <= 1'b0;
            if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
        end else if (!hold) begin
            r_bundle <= w_id_bundle;
            r_valid  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, directed corner sequences and random stimulus against a behavioural model
module tb_id_ex_stage;
    typedef struct packed {
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic [1:0]  aluop;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } bun_t;

    typedef struct {
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] exrd;
        logic       exmr;
        logic       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic hold = 1'b0;
    logic [6:0] opc = '0;
    bun_t in_b = '0;
    bun_t got;
    bun_t m_b = '0;
    logic m_valid = 1'b0;
    int   m_cnt = 0;
    int   errs = 0;
    int   checks = 0;

    logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_valid, stall;
    logic [15:0] bubble_cnt;

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_opcode(opc),
        .id_alusrc(in_b.alusrc), .id_memtoreg(in_b.memtoreg), .id_regwrite(in_b.regwrite),
        .id_memread(in_b.memread), .id_memwrite(in_b.memwrite), .id_branch(in_b.branch),
        .id_aluop(in_b.aluop), .id_pc(in_b.pc), .id_rd1(in_b.rd1), .id_rd2(in_b.rd2),
        .id_imm(in_b.imm), .id_rs1(in_b.rs1), .id_rs2(in_b.rs2), .id_rd(in_b.rd),
        .id_funct3(in_b.f3), .id_funct7(in_b.f7), .flush(flush), .hold(hold),
        .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
        .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    assign got = {ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                  ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    function automatic logic model_haz();
        logic r1, r2;
        r1 = !(opc == 7'b0110111 || opc == 7'b1101111);
        r2 = (opc == 7'b0110011 || opc == 7'b0100011 || opc == 7'b1100011);
        return m_valid && m_b.memread && m_b.rd != 0 &&
               ((r1 && m_b.rd == in_b.rs1) || (r2 && m_b.rd == in_b.rs2));
    endfunction

    task automatic check(string nm, logic [199:0] a, logic [199:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic model_reset();
        m_b = '0;
        m_valid = 1'b0;
        m_cnt = 0;
    endtask

    task automatic settle();
        #1;
        check("stall", 200'(stall), 200'(model_haz() && !flush && !hold));
    endtask

    task automatic step();
        @(posedge clk);
        if (flush || (model_haz() && !hold)) begin
            m_b = '0;
            m_valid = 1'b0;
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (!hold) begin
            m_b = in_b;
            m_valid = 1'b1;
        end
        #1;
        check("ex_bundle", 200'(got), 200'(m_b));
        check("ex_valid", 200'(ex_valid), 200'(m_valid));
        check("bubble_cnt", 200'(bubble_cnt), 200'(m_cnt));
    endtask

    task automatic load_ex(logic [4:0] rd, logic mr);
        in_b = '0;
        in_b.memread = mr;
        in_b.rd = rd;
        opc = 7'b0000011;
        flush = 1'b0;
        hold = 1'b0;
        settle();
        step();
    endtask

    function automatic bun_t rand_b();
        bun_t b;
        b.alusrc = 1'($urandom_range(1));
        b.memtoreg = 1'($urandom_range(1));
        b.regwrite = 1'($urandom_range(1));
        b.memread = 1'($urandom_range(1));
        b.memwrite = 1'($urandom_range(1));
        b.branch = 1'($urandom_range(1));
        b.aluop = 2'($urandom_range(3));
        b.pc = $urandom();
        b.rd1 = $urandom();
        b.rd2 = $urandom();
        b.imm = $urandom();
        b.rs1 = 5'($urandom_range(3));
        b.rs2 = 5'($urandom_range(3));
        b.rd = 5'($urandom_range(3));
        b.f3 = 3'($urandom_range(7));
        b.f7 = 7'($urandom_range(127));
        return b;
    endfunction

    logic [6:0] ops [8] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
                            7'b1101111, 7'b0010011, 7'b0000011, 7'b1100111};
    vec_t vecs [10];
    int   c0;

    initial begin
        vecs[0] = '{7'b0110111, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0};
        vecs[1] = '{7'b0010011, 5'd3, 5'd6, 5'd6, 1'b1, 1'b0};
        vecs[2] = '{7'b0100011, 5'd1, 5'd6, 5'd6, 1'b1, 1'b1};
        vecs[3] = '{7'b0110011, 5'd6, 5'd2, 5'd6, 1'b1, 1'b1};
        vecs[4] = '{7'b0110011, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0};
        vecs[5] = '{7'b1101111, 5'd6, 5'd6, 5'd6, 1'b1, 1'b0};
        vecs[6] = '{7'b1100011, 5'd1, 5'd6, 5'd6, 1'b1, 1'b1};
        vecs[7] = '{7'b0000011, 5'd6, 5'd0, 5'd6, 1'b1, 1'b1};
        vecs[8] = '{7'b0110011, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0};
        vecs[9] = '{7'b0110011, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("rst_bundle", 200'(got), 200'(0));
        check("rst_valid", 200'(ex_valid), 200'(0));
        check("rst_cnt", 200'(bubble_cnt), 200'(0));
        check("rst_stall", 200'(stall), 200'(0));
        reset = 1'b0;
        in_b = '0;
        in_b.regwrite = 1'b1;
        in_b.rd = 5'd5;
        settle();
        step();
        check("post_rst_regwrite", 200'(ex_regwrite), 200'(1));
        check("post_rst_rd", 200'(ex_rd), 200'(5));
        check("post_rst_valid", 200'(ex_valid), 200'(1));

        for (int i = 0; i < 10; i++) begin
            load_ex(vecs[i].exrd, vecs[i].exmr);
            in_b = '0;
            opc = vecs[i].op;
            in_b.rs1 = vecs[i].rs1;
            in_b.rs2 = vecs[i].rs2;
            #1;
            check($sformatf("vec%0d_stall", i), 200'(stall), 200'(vecs[i].exp));
            settle();
            step();
        end

        load_ex(5'd6, 1'b1);
        c0 = int'(bubble_cnt);
        in_b = '0;
        opc = 7'b0110011;
        in_b.rs1 = 5'd6;
        in_b.rs2 = 5'd2;
        in_b.rd = 5'd7;
        in_b.regwrite = 1'b1;
        #1;
        check("lu_stall", 200'(stall), 200'(1));
        step();
        check("lu_bubble_valid", 200'(ex_valid), 200'(0));
        check("lu_bubble_ctrl", 200'({ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_aluop}), 200'(0));
        check("lu_cnt", 200'(bubble_cnt), 200'(c0 + 1));
        #1;
        check("lu_stall_clear", 200'(stall), 200'(0));
        step();
        check("lu_capture_rd", 200'(ex_rd), 200'(7));
        check("lu_capture_valid", 200'(ex_valid), 200'(1));

        load_ex(5'd6, 1'b1);
        c0 = int'(bubble_cnt);
        in_b = '0;
        opc = 7'b0110011;
        in_b.rs1 = 5'd6;
        flush = 1'b1;
        #1;
        check("flush_stall", 200'(stall), 200'(0));
        step();
        check("flush_valid", 200'(ex_valid), 200'(0));
        check("flush_cnt", 200'(bubble_cnt), 200'(c0 + 1));
        flush = 1'b0;

        load_ex(5'd6, 1'b1);
        c0 = int'(bubble_cnt);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_b = rand_b();
            in_b.rs1 = 5'd6;
            opc = 7'b0110011;
            #1;
            check("hold_stall", 200'(stall), 200'(0));
            step();
            check("hold_rd", 200'(ex_rd), 200'(6));
            check("hold_cnt", 200'(bubble_cnt), 200'(c0));
        end
        hold = 1'b0;
        in_b.rs1 = 5'd7;
        in_b.rs2 = 5'd7;
        settle();
        step();
        check("hold_release_pc", 200'(ex_pc), 200'(in_b.pc));
        check("hold_release_valid", 200'(ex_valid), 200'(1));

        load_ex(5'd6, 1'b1);
        in_b = '0;
        opc = 7'b0110011;
        in_b.rs1 = 5'd6;
        in_b.rd = 5'd9;
        #1;
        check("midrst_pre_stall", 200'(stall), 200'(1));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_stall", 200'(stall), 200'(0));
        check("midrst_bundle", 200'(got), 200'(0));
        check("midrst_valid", 200'(ex_valid), 200'(0));
        check("midrst_cnt", 200'(bubble_cnt), 200'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step();
        check("midrst_first_rd", 200'(ex_rd), 200'(9));

        for (int i = 0; i < 2000; i++) begin
            flush = ($urandom_range(7) == 0);
            hold = ($urandom_range(5) == 0);
            opc = ops[$urandom_range(7)];
            in_b = rand_b();
            settle();
            step();
        end

        flush = 1'b0;
        hold = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        flush = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", 200'(bubble_cnt), 200'(16'hFFFE));
        @(posedge clk);
        #1;
        check("sat_ffff", 200'(bubble_cnt), 200'(16'hFFFF));
        repeat (5) @(posedge clk);
        #1;
        check("sat_stick", 200'(bubble_cnt), 200'(16'hFFFF));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
